// File: rtl/led_link_indicator.sv
// Per-port LED pattern generator: merges link status, activity strobe and flap
// level into a registered LED drive and a 2-bit mode code.
module led_link_indicator #(
  parameter int unsigned BlinkHalf = 25000000,
  parameter int unsigned ActHalf   = 2500000,
  parameter int unsigned FlapHold  = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       link_up,
  input  logic       activity,
  input  logic       flap,
  output logic       led,
  output logic [1:0] mode
);

  localparam int unsigned BW = $clog2(BlinkHalf * 2) + 1;
  localparam int unsigned AW = $clog2(ActHalf * 2) + 1;
  localparam int unsigned HW = $clog2(FlapHold * 2) + 1;

  localparam logic [1:0] ModeDown = 2'd0;
  localparam logic [1:0] ModeUp   = 2'd1;
  localparam logic [1:0] ModeAct  = 2'd2;
  localparam logic [1:0] ModeFlap = 2'd3;

  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_phase, blink_phase_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic [AW-1:0] act_cnt, act_cnt_nxt;
  logic          led_nxt;
  logic [1:0]    mode_nxt;

  // Next-state counters, then mode/LED selection from those next values
  always_comb begin
    blink_cnt_nxt   = blink_cnt + BW'(1);
    blink_phase_nxt = blink_phase;
    hold_nxt        = hold;
    act_cnt_nxt     = act_cnt;
    led_nxt         = 1'b1;
    mode_nxt        = ModeUp;

    if (blink_cnt == BW'(BlinkHalf - 1)) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase;
    end

    if (flap)
      hold_nxt = HW'(FlapHold);
    else if (hold != '0)
      hold_nxt = hold - HW'(1);

    // A wink is only re-armed on its last cycle, so held activity blinks gaplessly
    if (!link_up)
      act_cnt_nxt = '0;
    else if (activity && (act_cnt <= AW'(1)))
      act_cnt_nxt = AW'(2 * ActHalf);
    else if (act_cnt != '0)
      act_cnt_nxt = act_cnt - AW'(1);

    if (flap || (hold_nxt != '0)) begin
      mode_nxt = ModeFlap;
      led_nxt  = blink_phase_nxt;
    end else if (!link_up) begin
      mode_nxt = ModeDown;
      led_nxt  = 1'b0;
    end else if (act_cnt_nxt != '0) begin
      mode_nxt = ModeAct;
      led_nxt  = (act_cnt_nxt <= AW'(ActHalf));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      hold        <= '0;
      act_cnt     <= '0;
      led         <= 1'b0;
      mode        <= ModeDown;
    end else begin
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      hold        <= hold_nxt;
      act_cnt     <= act_cnt_nxt;
      led         <= led_nxt;
      mode        <= mode_nxt;
    end
  end

endmodule

// File: tb/tb_led_link_indicator.sv
// Directed bench for led_link_indicator with BlinkHalf=4, ActHalf=3, FlapHold=8.
module tb_led_link_indicator;

  logic       clk;
  logic       reset_n;
  logic       link_up;
  logic       activity;
  logic       flap;
  logic       led;
  logic [1:0] mode;

  int tests;
  int fails;
  int cyc;

  led_link_indicator #(
    .BlinkHalf(4),
    .ActHalf  (3),
    .FlapHold (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .link_up (link_up),
    .activity(activity),
    .flap    (flap),
    .led     (led),
    .mode    (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Blink phase after edge e counted from reset release
  function automatic logic phase_at(input int e);
    return ((e / 4) % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic lu);
    link_up  = lu;
    activity = 1'b0;
    flap     = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic advance_to(input int e);
    while (cyc < e) tick();
  endtask

  task automatic test_reset();
    link_up = 1'b1; activity = 1'b0; flap = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (led !== 1'b0 || mode !== 2'd0) begin
      fails++;
      $display("FAIL reset_assert: led=%b mode=%0d, required led=0 mode=0", led, mode);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (led !== 1'b0 || mode !== 2'd0) begin
      fails++;
      $display("FAIL reset_held: led=%b mode=%0d, required led=0 mode=0", led, mode);
    end
    reset_n = 1'b1;
    cyc = 0;
    tick();
    tests++;
    if (led !== 1'b1 || mode !== 2'd1) begin
      fails++;
      $display("FAIL reset_release: led=%b mode=%0d, required led=1 mode=1", led, mode);
    end
  endtask

  task automatic test_single_activity();
    logic       exp_led;
    logic [1:0] exp_mode;
    do_reset(1'b1);
    advance_to(9);
    activity = 1'b1;
    for (int e = 10; e <= 18; e++) begin
      tick();
      activity = (cyc == 11);
      exp_led  = !(e >= 10 && e <= 12);
      exp_mode = (e <= 15) ? 2'd2 : 2'd1;
      tests++;
      if (led !== exp_led || mode !== exp_mode) begin
        fails++;
        $display("FAIL single_act edge %0d: led=%b mode=%0d, required led=%b mode=%0d",
                 e, led, mode, exp_led, exp_mode);
      end
    end
  endtask

  task automatic test_activity_held();
    logic exp_led;
    do_reset(1'b1);
    advance_to(4);
    activity = 1'b1;
    for (int e = 5; e <= 24; e++) begin
      tick();
      exp_led = (((e - 5) % 6) >= 3);
      tests++;
      if (led !== exp_led || mode !== 2'd2) begin
        fails++;
        $display("FAIL act_held edge %0d: led=%b mode=%0d, required led=%b mode=2",
                 e, led, mode, exp_led);
      end
    end
    activity = 1'b0;
  endtask

  task automatic test_flap_pulse();
    logic       exp_led;
    logic [1:0] exp_mode;
    do_reset(1'b1);
    advance_to(19);
    flap = 1'b1;
    for (int e = 20; e <= 29; e++) begin
      tick();
      flap = 1'b0;
      exp_mode = (e <= 27) ? 2'd3 : 2'd1;
      exp_led  = (e <= 27) ? phase_at(e) : 1'b1;
      tests++;
      if (led !== exp_led || mode !== exp_mode) begin
        fails++;
        $display("FAIL flap_pulse edge %0d: led=%b mode=%0d, required led=%b mode=%0d",
                 e, led, mode, exp_led, exp_mode);
      end
    end
  endtask

  task automatic test_flap_link_down();
    logic       exp_led;
    logic [1:0] exp_mode;
    do_reset(1'b0);
    flap = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (cyc == 10) flap = 1'b0;
      exp_mode = (e <= 17) ? 2'd3 : 2'd0;
      exp_led  = (e <= 17) ? phase_at(e) : 1'b0;
      tests++;
      if (led !== exp_led || mode !== exp_mode) begin
        fails++;
        $display("FAIL flap_linkdown edge %0d: led=%b mode=%0d, required led=%b mode=%0d",
                 e, led, mode, exp_led, exp_mode);
      end
    end
  endtask

  task automatic test_link_drop();
    logic       exp_led;
    logic [1:0] exp_mode;
    do_reset(1'b1);
    advance_to(9);
    activity = 1'b1;
    for (int e = 10; e <= 16; e++) begin
      tick();
      activity = 1'b0;
      if (cyc == 11) link_up = 1'b0;
      if (cyc == 12) link_up = 1'b1;
      if (e <= 11) begin
        exp_mode = 2'd2; exp_led = 1'b0;
      end else if (e == 12) begin
        exp_mode = 2'd0; exp_led = 1'b0;
      end else begin
        exp_mode = 2'd1; exp_led = 1'b1;
      end
      tests++;
      if (led !== exp_led || mode !== exp_mode) begin
        fails++;
        $display("FAIL link_drop edge %0d: led=%b mode=%0d, required led=%b mode=%0d",
                 e, led, mode, exp_led, exp_mode);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Flap and accepted activity together: flap wins and the wink expires unseen
    do_reset(1'b1);
    advance_to(3);
    flap = 1'b1;
    activity = 1'b1;
    tick();
    activity = 1'b0;
    tests++;
    if (mode !== 2'd3 || led !== phase_at(4)) begin
      fails++;
      $display("FAIL flap_and_act: led=%b mode=%0d, required led=%b mode=3",
               led, mode, phase_at(4));
    end
    advance_to(12);
    flap = 1'b0;
    advance_to(20);
    tests++;
    if (mode !== 2'd1 || led !== 1'b1) begin
      fails++;
      $display("FAIL flap_act_expired: led=%b mode=%0d, required led=1 mode=1", led, mode);
    end
    // Reset mid-wink abandons it; the first edge after release is a fresh start
    activity = 1'b1;
    tick();
    activity = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (led !== 1'b0 || mode !== 2'd0) begin
      fails++;
      $display("FAIL reset_midwink: led=%b mode=%0d, required led=0 mode=0", led, mode);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    tick();
    tests++;
    if (led !== 1'b1 || mode !== 2'd1) begin
      fails++;
      $display("FAIL fresh_start: led=%b mode=%0d, required led=1 mode=1", led, mode);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    reset_n  = 1'b1;
    link_up  = 1'b0;
    activity = 1'b0;
    flap     = 1'b0;
    test_reset();
    test_single_activity();
    test_activity_held();
    test_flap_pulse();
    test_flap_link_down();
    test_link_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
